// File: rtl/integer_divider_24by16.sv
// ---------------------------------------------------------------------------
// integer_divider_24by16
//
// Fully pipelined unsigned restoring divider:
//   quotient = floor(dividend / divisor)
// The divider takes one operand pair per clock and returns one quotient per
// clock. Each result appears DIVIDEND_W clocks after its operands.
// Each stage resolves one quotient bit, MSB first. It shares a single
// DIVIDEND_W-bit register between the unprocessed dividend bits, which shift
// out at the top, and the quotient bits formed so far, which shift in at the
// bottom. After the last stage, that register holds the complete quotient.
// Dividing by zero gives all ones, which the restoring algorithm produces
// without any extra logic.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset; clears every register
//   dividend   in   [DIVIDEND_W-1:0] unsigned dividend (not pre-registered)
//   divisor    in   [DIVISOR_W-1:0]  unsigned divisor  (not pre-registered)
//   quotient   out  [DIVIDEND_W-1:0] registered quotient, 0 during fill
//   remainder  out  [DIVISOR_W-1:0]  registered remainder, 0 during fill
//              (present only when INTEGER_DIVIDER_REMAINDER_EN is defined)
//
// Optional feature macro: INTEGER_DIVIDER_REMAINDER_EN
// ---------------------------------------------------------------------------
module integer_divider_24by16 #(
  parameter int DIVIDEND_W = 24,
  parameter int DIVISOR_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
`ifdef INTEGER_DIVIDER_REMAINDER_EN
  output logic [DIVISOR_W-1:0]  remainder,
`endif
  output logic [DIVIDEND_W-1:0] quotient
);

  // One restoring step. The result is {quotient_bit, new_partial_remainder}.
  // The subtract is one bit wider than {rem, bit} so that its MSB is the borrow.
  function automatic logic [DIVISOR_W:0] div_step(
    input logic [DIVISOR_W-1:0] rem,
    input logic                 nbit,
    input logic [DIVISOR_W-1:0] dvs
  );
    logic [DIVISOR_W:0]   shifted;
    logic [DIVISOR_W+1:0] trial;
    shifted = {rem, nbit};
    trial   = {1'b0, shifted} - {2'b00, dvs};
    if (trial[DIVISOR_W+1]) begin
      // Borrow: shifted < divisor, so it fits in DIVISOR_W bits.
      div_step = {1'b0, shifted[DIVISOR_W-1:0]};
    end else begin
      // No borrow: the difference is below divisor (or equal to shifted
      // when divisor is 0), so the low DIVISOR_W bits hold it.
      div_step = {1'b1, trial[DIVISOR_W-1:0]};
    end
  endfunction

  // Per-stage registers. The last stage keeps only the quotient, plus the
  // remainder when the optional output is enabled.
  logic [DIVIDEND_W-1:0] dq_q  [DIVIDEND_W];
  logic [DIVIDEND_W-1:0] dq_d  [DIVIDEND_W];
  logic [DIVISOR_W-1:0]  rem_q [DIVIDEND_W-1];
  logic [DIVISOR_W-1:0]  rem_d [DIVIDEND_W-1];
  logic [DIVISOR_W-1:0]  dvs_q [DIVIDEND_W-1];
  logic [DIVISOR_W-1:0]  dvs_d [DIVIDEND_W-1];

  // Fill tracker. The output register itself acts as the final "primed"
  // position, because it loads zero until primed_q[DIVIDEND_W-2] is set.
  logic [DIVIDEND_W-2:0] primed_q;
  logic [DIVIDEND_W-2:0] primed_d;

`ifdef INTEGER_DIVIDER_REMAINDER_EN
  logic [DIVISOR_W-1:0]  rem_out_q;
  logic [DIVISOR_W-1:0]  rem_out_d;
`endif

  // Stage inputs: stage 0 reads the ports directly, stage i reads stage i-1.
  logic [DIVIDEND_W-1:0] dq_in_s  [DIVIDEND_W];
  logic [DIVISOR_W-1:0]  rem_in_s [DIVIDEND_W];
  logic [DIVISOR_W-1:0]  dvs_in_s [DIVIDEND_W];
  logic [DIVISOR_W:0]    step_s   [DIVIDEND_W];

  // Route each stage's input from the ports or from the previous stage.
  always_comb begin
    dq_in_s[0]  = dividend;
    rem_in_s[0] = {DIVISOR_W{1'b0}};
    dvs_in_s[0] = divisor;
    for (int i = 1; i < DIVIDEND_W; i++) begin
      dq_in_s[i]  = dq_q[i-1];
      rem_in_s[i] = rem_q[i-1];
      dvs_in_s[i] = dvs_q[i-1];
    end
  end

  // Compute each stage's next state and gate the output stage during fill.
  always_comb begin
    for (int i = 0; i < DIVIDEND_W; i++) begin
      step_s[i] = div_step(rem_in_s[i], dq_in_s[i][DIVIDEND_W-1], dvs_in_s[i]);
      dq_d[i]   = {dq_in_s[i][DIVIDEND_W-2:0], step_s[i][DIVISOR_W]};
    end
    for (int i = 0; i < DIVIDEND_W - 1; i++) begin
      rem_d[i] = step_s[i][DIVISOR_W-1:0];
      dvs_d[i] = dvs_in_s[i];
    end
    primed_d = {primed_q[DIVIDEND_W-3:0], 1'b1};
`ifdef INTEGER_DIVIDER_REMAINDER_EN
    rem_out_d = step_s[DIVIDEND_W-1][DIVISOR_W-1:0];
`endif
    // Until the fill reaches the output, the last stage holds results of
    // reset-valued (0/0) slots, so the output is forced to zero.
    if (primed_q[DIVIDEND_W-2]) begin
      dq_d[DIVIDEND_W-1] = dq_d[DIVIDEND_W-1];
    end else begin
      dq_d[DIVIDEND_W-1] = {DIVIDEND_W{1'b0}};
`ifdef INTEGER_DIVIDER_REMAINDER_EN
      rem_out_d = {DIVISOR_W{1'b0}};
`endif
    end
  end

  // Pipeline and fill registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DIVIDEND_W; i++) begin
        dq_q[i] <= {DIVIDEND_W{1'b0}};
      end
      for (int i = 0; i < DIVIDEND_W - 1; i++) begin
        rem_q[i] <= {DIVISOR_W{1'b0}};
        dvs_q[i] <= {DIVISOR_W{1'b0}};
      end
      primed_q <= {(DIVIDEND_W-1){1'b0}};
`ifdef INTEGER_DIVIDER_REMAINDER_EN
      rem_out_q <= {DIVISOR_W{1'b0}};
`endif
    end else begin
      for (int i = 0; i < DIVIDEND_W; i++) begin
        dq_q[i] <= dq_d[i];
      end
      for (int i = 0; i < DIVIDEND_W - 1; i++) begin
        rem_q[i] <= rem_d[i];
        dvs_q[i] <= dvs_d[i];
      end
      primed_q <= primed_d;
`ifdef INTEGER_DIVIDER_REMAINDER_EN
      rem_out_q <= rem_out_d;
`endif
    end
  end

  assign quotient = dq_q[DIVIDEND_W-1];
`ifdef INTEGER_DIVIDER_REMAINDER_EN
  assign remainder = rem_out_q;
`endif

endmodule

// File: tb/tb_integer_divider_24by16.sv
// ---------------------------------------------------------------------------
// Self-checking bench for integer_divider_24by16 (default 24/16 widths).
// Each clock, the bench applies one operand pair and pushes the golden result
// into a scoreboard queue, tagged with the edge at which it is due. When the
// DUT output is sampled on the falling edge, the bench pops the due entry and
// compares it with the output. While the pipeline fills after reset, zero is
// the required output.
// ---------------------------------------------------------------------------
module tb_integer_divider_24by16;

  localparam int DVD_W = 24;
  localparam int DVS_W = 16;
  localparam int LAT   = DVD_W;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic [DVD_W-1:0] quotient;
`ifdef INTEGER_DIVIDER_REMAINDER_EN
  logic [DVS_W-1:0] remainder;
`endif

  typedef struct {
    int               due;
    logic [DVD_W-1:0] q;
    logic [DVS_W-1:0] r;
  } exp_t;

  exp_t sb[$];
  int   edges;
  int   total;
  int   bad;

  always #5 clk = ~clk;

  integer_divider_24by16 #(.DIVIDEND_W(DVD_W), .DIVISOR_W(DVS_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .dividend (dividend),
    .divisor  (divisor),
`ifdef INTEGER_DIVIDER_REMAINDER_EN
    .remainder(remainder),
`endif
    .quotient (quotient)
  );

  // Drive one operand pair through one clock. Return the sampled outputs and
  // the expected values (the popped scoreboard entry, or zero during fill).
  task automatic step(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b,
                      output logic [DVD_W-1:0] got_q, output logic [DVD_W-1:0] exp_q,
                      output logic [DVS_W-1:0] got_r, output logic [DVS_W-1:0] exp_r);
    exp_t e;
    dividend = a;
    divisor  = b;
    e.due = edges + LAT - 1;
    if (b == 16'd0) begin
      e.q = {DVD_W{1'b1}};
      e.r = a[DVS_W-1:0];
    end else begin
      e.q = a / {8'd0, b};
      e.r = DVS_W'(a % {8'd0, b});
    end
    sb.push_back(e);
    @(posedge clk);
    edges++;
    @(negedge clk);
    got_q = quotient;
`ifdef INTEGER_DIVIDER_REMAINDER_EN
    got_r = remainder;
`else
    got_r = 16'd0;
`endif
    if (sb.size() > 0 && sb[0].due == edges - 1) begin
      e     = sb.pop_front();
      exp_q = e.q;
      exp_r = e.r;
    end else begin
      exp_q = 24'd0;
      exp_r = 16'd0;
    end
  endtask

  // Hold reset for a number of clocks, then release it between edges.
  task automatic apply_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    edges = 0;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    dividend = 24'h123456;
    divisor  = 16'h0007;
    #1;
    total++;
    if (quotient !== 24'd0) begin
      bad++;
      $display("FAIL reset_q0: got %h want %h", quotient, 24'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (quotient !== 24'd0) begin
      bad++;
      $display("FAIL reset_hold_q: got %h want %h", quotient, 24'd0);
    end
`ifdef INTEGER_DIVIDER_REMAINDER_EN
    total++;
    if (remainder !== 16'd0) begin
      bad++;
      $display("FAIL reset_r: got %h want %h", remainder, 16'd0);
    end
`endif
    reset_n = 1'b1;
    sb.delete();
    edges = 0;
  endtask

  task automatic test_gain();
    logic [DVD_W-1:0] gq, eq;
    logic [DVS_W-1:0] gr, er;
    for (int i = 0; i < LAT + 8; i++) begin
      step(24'h010000, 16'h0100, gq, eq, gr, er);
      total++;
      if (gq !== eq || (i >= LAT - 1 && gq !== 24'h000100)) begin
        bad++;
        $display("FAIL gain_q[%0d]: got %h want %h", i, gq, (i >= LAT - 1) ? 24'h000100 : 24'd0);
      end
`ifdef INTEGER_DIVIDER_REMAINDER_EN
      total++;
      if (gr !== er) begin
        bad++;
        $display("FAIL gain_r[%0d]: got %h want %h", i, gr, er);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [DVD_W-1:0] gq, eq;
    logic [DVS_W-1:0] gr, er;
    logic [DVD_W-1:0] a_tab [4];
    logic [DVS_W-1:0] b_tab [4];
    logic [DVD_W-1:0] q_tab [4];
    logic [DVS_W-1:0] r_tab [4];
    a_tab = '{24'h00FFFF, 24'd100, 24'hFFFFFF, 24'hFFFFFF};
    b_tab = '{16'd3, 16'd7, 16'd1, 16'hFFFF};
    q_tab = '{24'h005555, 24'd14, 24'hFFFFFF, 24'h000100};
    r_tab = '{16'd0, 16'd2, 16'd0, 16'd255};
    // The gain stream fills the pipeline; the four pairs follow it directly.
    for (int i = 0; i < 4 + LAT; i++) begin
      if (i < 4) step(a_tab[i], b_tab[i], gq, eq, gr, er);
      else       step(24'h000001, 16'h0001, gq, eq, gr, er);
      // Step i drives its pair before edge i and samples after edge i, so
      // pair k appears at step k + LAT - 1.
      if (i >= LAT - 1 && i < LAT + 3) begin
        eq = q_tab[i-LAT+1];
        er = r_tab[i-LAT+1];
      end
      total++;
      if (gq !== eq) begin
        bad++;
        $display("FAIL b2b_q[%0d]: got %h want %h", i, gq, eq);
      end
`ifdef INTEGER_DIVIDER_REMAINDER_EN
      total++;
      if (gr !== er) begin
        bad++;
        $display("FAIL b2b_r[%0d]: got %h want %h", i, gr, er);
      end
`endif
    end
  endtask

  task automatic test_boundaries();
    logic [DVD_W-1:0] gq, eq;
    logic [DVS_W-1:0] gr, er;
    logic [DVD_W-1:0] a_tab [6];
    logic [DVS_W-1:0] b_tab [6];
    a_tab = '{24'd0, 24'h00FFFE, 24'h00FFFF, 24'd100, 24'd1234, 24'd100};
    b_tab = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd7, 16'd0, 16'd7};
    for (int i = 0; i < 6 + LAT; i++) begin
      if (i < 6) step(a_tab[i], b_tab[i], gq, eq, gr, er);
      else       step(24'h000009, 16'h0003, gq, eq, gr, er);
      total++;
      if (gq !== eq) begin
        bad++;
        $display("FAIL bound_q[%0d]: got %h want %h", i, gq, eq);
      end
`ifdef INTEGER_DIVIDER_REMAINDER_EN
      total++;
      if (gr !== er) begin
        bad++;
        $display("FAIL bound_r[%0d]: got %h want %h", i, gr, er);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    logic [DVD_W-1:0] gq, eq;
    logic [DVS_W-1:0] gr, er;
    for (int i = 0; i < 30; i++) begin
      step(24'($urandom), 16'($urandom_range(0, 65535)), gq, eq, gr, er);
      total++;
      if (gq !== eq) begin
        bad++;
        $display("FAIL pre_rst_q[%0d]: got %h want %h", i, gq, eq);
      end
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (quotient !== 24'd0) begin
      bad++;
      $display("FAIL mid_rst_async_q: got %h want %h", quotient, 24'd0);
    end
    apply_reset(3);
    for (int i = 0; i < LAT + 20; i++) begin
      step(24'($urandom), 16'($urandom_range(1, 300)), gq, eq, gr, er);
      total++;
      if (gq !== eq) begin
        bad++;
        $display("FAIL post_rst_q[%0d]: got %h want %h", i, gq, eq);
      end
`ifdef INTEGER_DIVIDER_REMAINDER_EN
      total++;
      if (gr !== er) begin
        bad++;
        $display("FAIL post_rst_r[%0d]: got %h want %h", i, gr, er);
      end
`endif
    end
  endtask

  task automatic test_soak();
    logic [DVD_W-1:0] gq, eq;
    logic [DVS_W-1:0] gr, er;
    logic [DVS_W-1:0] b;
    for (int i = 0; i < 10000 + LAT; i++) begin
      case ($urandom_range(0, 3))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      step(24'($urandom), b, gq, eq, gr, er);
      total++;
      if (gq !== eq) begin
        bad++;
        $display("FAIL soak_q[%0d]: got %h want %h", i, gq, eq);
      end
`ifdef INTEGER_DIVIDER_REMAINDER_EN
      total++;
      if (gr !== er) begin
        bad++;
        $display("FAIL soak_r[%0d]: got %h want %h", i, gr, er);
      end
`endif
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    edges = 0;
    test_reset();
    test_gain();
    test_back_to_back();
    test_boundaries();
    test_reset_mid();
    test_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
